// File: rtl/ram_line_ctrl.sv
// Cache-line RAM controller: one outstanding read or write, valid/ready on both sides.
// Optional address range checking is enabled by defining RAM_CTRL_RANGE_CHECK_EN.
module ram_line_ctrl #(
  parameter int unsigned CACHE_LINE_WIDTH = 128,
  parameter int unsigned RAM_DEPTH        = 32768,
  parameter logic [31:0] BASE_ADDR        = 32'h8000_0000
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [31:0]                     req_addr_i,
  input  logic                            req_we_i,
  input  logic [CACHE_LINE_WIDTH-1:0]     req_wdata_i,
  input  logic [CACHE_LINE_WIDTH/8-1:0]   req_wstrb_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [CACHE_LINE_WIDTH-1:0]     rsp_rdata_o,
  output logic                            rsp_err_o,
  input  logic                            prog_mode_i,
  output logic [$clog2(RAM_DEPTH)-1:0]    ram_addr_o,
  output logic [CACHE_LINE_WIDTH-1:0]     ram_wdata_o,
  output logic [CACHE_LINE_WIDTH/8-1:0]   ram_wstrb_o,
  output logic                            ram_rd_en_o,
  input  logic [CACHE_LINE_WIDTH-1:0]     ram_rdata_i
);

  localparam int unsigned BYTES = CACHE_LINE_WIDTH / 8;
  localparam int unsigned AW    = $clog2(RAM_DEPTH);
  localparam int unsigned LW    = $clog2(BYTES / 4);
  localparam logic [AW-1:0] LineMask = ~AW'((2 ** LW) - 1);

  typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

  state_e                      state_q, state_d;
  logic                        ready_q;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [CACHE_LINE_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                        rsp_err_q, rsp_err_d;
  logic [31:0]                 offset;
  logic                        in_range;
  logic                        accept;

  // Word address relative to RAM base; out-of-range addresses alias by truncation.
  assign offset     = req_addr_i - BASE_ADDR;
  assign ram_addr_o = AW'(offset >> 2) & LineMask;

`ifdef RAM_CTRL_RANGE_CHECK_EN
  localparam logic [32:0] Limit = {1'b0, BASE_ADDR} + (33'(RAM_DEPTH) * 33'd4);
  assign in_range = (req_addr_i >= BASE_ADDR) && ({1'b0, req_addr_i} < Limit);
`else
  assign in_range = 1'b1;
`endif

  assign req_ready_o = (state_q == StIdle) && ready_q && !prog_mode_i;
  assign accept      = req_valid_i && req_ready_o;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ram_rd_en_o = 1'b0;
    ram_wstrb_o = '0;
    ram_wdata_o = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!in_range) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (req_we_i) begin
            ram_wstrb_o = req_wstrb_i;
            ram_wdata_o = req_wdata_i;
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
          end else begin
            ram_rd_en_o = 1'b1;
            state_d     = StRdWait;
          end
        end
      end
      StRdWait: begin
        // RAM output is registered, so data is valid the cycle after rd_en.
        rsp_rdata_d = ram_rdata_i;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ram_line_ctrl.sv
// Directed bench for ram_line_ctrl with a behavioural registered-read line RAM.
// Range-check expectations follow RAM_CTRL_RANGE_CHECK_EN.
module tb_ram_line_ctrl;

  localparam int unsigned W     = 128;
  localparam int unsigned BYTES = 16;
  localparam int unsigned AW    = 15;

  localparam logic [127:0] L1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] L2 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready, req_we;
  logic [31:0]      req_addr;
  logic [W-1:0]     req_wdata;
  logic [BYTES-1:0] req_wstrb;
  logic             rsp_valid, rsp_ready, rsp_err, prog_mode;
  logic [W-1:0]     rsp_rdata;
  logic [AW-1:0]    ram_addr;
  logic [W-1:0]     ram_wdata, ram_rdata;
  logic [BYTES-1:0] ram_wstrb;
  logic             ram_rd_en;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mem [0:8191];

  always #5 clk = ~clk;

  ram_line_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_we_i    (req_we),
    .req_wdata_i (req_wdata),
    .req_wstrb_i (req_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .prog_mode_i (prog_mode),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_wstrb_o (ram_wstrb),
    .ram_rd_en_o (ram_rd_en),
    .ram_rdata_i (ram_rdata)
  );

  // Line RAM; lines 1 and 2 are reloaded while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[1] <= L1;
      mem[2] <= L2;
    end else begin
      if (ram_rd_en) ram_rdata <= mem[ram_addr[AW-1:2]];
      for (int b = 0; b < BYTES; b++) begin
        if (ram_wstrb[b]) mem[ram_addr[AW-1:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [31:0] a, input logic [127:0] d,
                       input logic [15:0] s);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    #1;
  endtask

  task automatic drop();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wstrb = '0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b0;
    prog_mode = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    #11 rst_n = 1'b1;
    #1 check("first_cycle_not_ready", req_ready, 0);
    tick();
    check("ready_after_edge", req_ready, 1);

    // Basic read of line 1 with a 5-cycle response stall
    start(1'b0, 32'h8000_0010, '0, '0);
    check("rd_en_at_T", ram_rd_en, 1);
    check("rd_addr_at_T", ram_addr, 15'd4);
    check("rd_no_wstrb", ram_wstrb, 0);
    tick();
    drop();
    check("rd_en_off_T1", ram_rd_en, 0);
    check("rd_no_valid_T1", rsp_valid, 0);
    check("rd_busy_T1", req_ready, 0);
    tick();
    check("rd_valid_T2", rsp_valid, 1);
    check("rd_data_T2", rsp_rdata, L1);
    check("rd_err_T2", rsp_err, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_rdata, L1);
      check("stall_not_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    #1 check("no_accept_in_hs", req_ready, 0);
    tick();
    rsp_ready = 1'b0;
    check("valid_clear_after_hs", rsp_valid, 0);
    check("ready_after_hs", req_ready, 1);

    // Masked write to word 0 of line 2
    start(1'b1, 32'h8000_0020, 128'hCAFEF00D_CAFEF00D_CAFEF00D_DEADBEEF, 16'h000F);
    check("wr_addr_at_T", ram_addr, 15'd8);
    check("wr_wstrb_at_T", ram_wstrb, 16'h000F);
    check("wr_wdata_at_T", ram_wdata, 128'hCAFEF00D_CAFEF00D_CAFEF00D_DEADBEEF);
    check("wr_no_rd_en", ram_rd_en, 0);
    tick();
    drop();
    check("wr_valid_T1", rsp_valid, 1);
    check("wr_rdata_zero", rsp_rdata, 0);
    check("wr_wstrb_off_T1", ram_wstrb, 0);
    handshake();

    // Readback with ignored byte-offset bits
    start(1'b0, 32'h8000_0024, '0, '0);
    check("rb_addr_aligned", ram_addr, 15'd8);
    tick();
    drop();
    tick();
    check("rb_data", rsp_rdata, 128'h4444_4444_3333_3333_2222_2222_DEADBEEF);
    handshake();

    // Zero-strobe write responds but leaves RAM alone
    start(1'b1, 32'h8000_0010, {128{1'b1}}, 16'h0000);
    check("zs_wstrb_zero", ram_wstrb, 0);
    tick();
    drop();
    check("zs_valid_T1", rsp_valid, 1);
    handshake();
    start(1'b0, 32'h8000_0010, '0, '0);
    tick();
    drop();
    tick();
    check("zs_line_unchanged", rsp_rdata, L1);
    handshake();

    // prog_mode blocks new requests only
    prog_mode = 1'b1;
    start(1'b0, 32'h8000_0010, '0, '0);
    check("pm_not_ready", req_ready, 0);
    check("pm_no_rd_en", ram_rd_en, 0);
    check("pm_no_wstrb", ram_wstrb, 0);
    tick();
    check("pm_no_rsp", rsp_valid, 0);
    prog_mode = 1'b0;
    #1 check("pm_release_ready", req_ready, 1);
    check("pm_release_rd_en", ram_rd_en, 1);
    tick();
    drop();
    prog_mode = 1'b1;
    tick();
    check("pm_inflight_valid", rsp_valid, 1);
    check("pm_inflight_data", rsp_rdata, L1);
    handshake();
    check("pm_blocks_after_hs", req_ready, 0);
    prog_mode = 1'b0;

    // Address just past the RAM end
    start(1'b0, 32'h8002_0010, '0, '0);
`ifdef RAM_CTRL_RANGE_CHECK_EN
    check("oor_no_rd_en", ram_rd_en, 0);
    tick();
    drop();
    check("oor_valid_T1", rsp_valid, 1);
    check("oor_err", rsp_err, 1);
    check("oor_rdata", rsp_rdata, 0);
`else
    check("alias_rd_en", ram_rd_en, 1);
    check("alias_addr", ram_addr, 15'd4);
    tick();
    drop();
    tick();
    check("alias_data", rsp_rdata, L1);
    check("alias_err", rsp_err, 0);
`endif
    handshake();

    // Reset while a response is pending
    start(1'b0, 32'h8000_0020, '0, '0);
    tick();
    drop();
    tick();
    check("pre_rst_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1 check("rst_resp_valid", rsp_valid, 0);
    check("rst_resp_rdata", rsp_rdata, 0);
    check("rst_resp_ready", req_ready, 0);
    #2 rst_n = 1'b1;
    #1 check("rst_resp_rel_ready", req_ready, 0);
    tick();
    check("rst_resp_ready_back", req_ready, 1);

    // Reset during RD_WAIT drops the read
    start(1'b0, 32'h8000_0010, '0, '0);
    tick();
    drop();
    rst_n = 1'b0;
    #1 check("rst_rw_valid", rsp_valid, 0);
    check("rst_rw_ready", req_ready, 0);
    tick();
    check("rst_rw_valid_held", rsp_valid, 0);
    #2 rst_n = 1'b1;
    #1 check("rst_rw_rel_ready", req_ready, 0);
    tick();
    check("rst_rw_ready_back", req_ready, 1);
    check("rst_rw_no_rsp", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_line_ctrl.md
RAM_LINE_CTRL -- requirements
Module: ram_line_ctrl

Interface
REQ-001 SHALL have parameter CACHE_LINE_WIDTH, default 128, meaning line width in bits (BYTES=CACHE_LINE_WIDTH/8).
REQ-002 SHALL have parameter RAM_DEPTH, default 32768, meaning RAM size in 32-bit words (AW=$clog2(RAM_DEPTH)).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning byte address of RAM word 0.
REQ-004 SHALL have ports, one per line:
 clk_i  in  1  single clock, rising edge.
 rst_ni  in  1  reset; asynchronous and active-low (fixed).
 req_valid_i  in  1  request valid.
 req_ready_o  out  1  request accepted when valid&ready.
 req_addr_i  in  32  byte address.
 req_we_i  in  1  1=write, 0=read.
 req_wdata_i  in  CACHE_LINE_WIDTH  write line.
 req_wstrb_i  in  BYTES  byte enables.
 rsp_valid_o  out  1  response valid.
 rsp_ready_i  in  1  response consumed when valid&ready.
 rsp_rdata_o  out  CACHE_LINE_WIDTH  read line; 0 for writes.
 rsp_err_o  out  1  address-range error.
 prog_mode_i  in  1  RAM being programmed over UART; block new requests.
 ram_addr_o  out  AW  RAM word address, line-aligned.
 ram_wdata_o  out  CACHE_LINE_WIDTH  RAM write data.
 ram_wstrb_o  out  BYTES  RAM byte strobes.
 ram_rd_en_o  out  1  RAM read enable.
 ram_rdata_i  in  CACHE_LINE_WIDTH  RAM registered read data (valid cycle after rd_en).

Function
REQ-005 SHALL implement FSM IDLE, RD_WAIT, RESP; one outstanding transaction.
REQ-006 req_ready_o SHALL be 1 only in IDLE with registered ready flag set and prog_mode_i=0.
REQ-007 On accept (cycle T), ram_addr_o SHALL be (req_addr_i-BASE_ADDR)[AW+1:2] with low $clog2(BYTES/4) bits forced 0; req_addr_i[$clog2(BYTES)-1:0] ignored.
REQ-008 Write accept SHALL drive ram_wstrb_o=req_wstrb_i, ram_wdata_o=req_wdata_i in cycle T only; go RESP; rsp_valid_o=1 at T+1, rsp_rdata_o=0.
REQ-009 Read accept SHALL drive ram_rd_en_o=1 in cycle T only; go RD_WAIT; in T+1 register ram_rdata_i into rsp_rdata_o; go RESP; rsp_valid_o=1 at T+2.
REQ-010 Outside accept cycles ram_wstrb_o SHALL be 0 and ram_rd_en_o SHALL be 0.
REQ-011 In RESP, rsp_valid_o, rsp_rdata_o, rsp_err_o SHALL hold stable until rsp_ready_i=1; then go IDLE, rsp_valid_o=0 next cycle.
REQ-012 Earliest next accept SHALL be the cycle after response handshake (no accept in handshake cycle).
REQ-013 prog_mode_i rising during RD_WAIT/RESP SHALL not abort the in-flight transaction; only new accepts are blocked.
REQ-014 Write with req_wstrb_i=0 SHALL still produce a response at T+1 with no RAM change.

Reset
REQ-015 rst_ni low SHALL asynchronously force IDLE, ready flag=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0; in-flight transaction dropped.
REQ-016 ready flag SHALL set on first clock edge after rst_ni rises, so req_ready_o=0 during reset and that first cycle.

Configuration
REQ-017 Macro RAM_CTRL_RANGE_CHECK_EN defined: request with req_addr_i<BASE_ADDR or >=BASE_ADDR+4*RAM_DEPTH SHALL issue no RAM access, go RESP, rsp_valid_o=1 at T+1 with rsp_err_o=1, rsp_rdata_o=0.
REQ-018 Macro undefined: rsp_err_o SHALL be constant 0; out-of-range addresses alias via truncation to AW bits.

Verification
REQ-019 Read 0x8000_0010, RAM line 1=0x0123..EF -> ram_rd_en_o at T, addr=4; rsp_valid_o at T+2, rdata=line 1, err=0.
REQ-020 Write 0x8000_0020, wstrb=16'h000F, wdata word0=0xDEADBEEF, then read back -> write rsp at T+1; readback word0=0xDEADBEEF, other words unchanged.
REQ-021 Read with rsp_ready_i=0 for 5 cycles -> rsp_valid_o/rdata stable 5 cycles; req_ready_o=0 throughout; ready again cycle after handshake.
REQ-022 prog_mode_i=1 with req_valid_i=1 -> req_ready_o=0, no RAM strobes; deassert -> accept next cycle.
REQ-023 rst_ni low in RD_WAIT -> rsp_valid_o=0 immediately; req_ready_o=0 until first edge after release, then 1.
REQ-024 With RAM_CTRL_RANGE_CHECK_EN, read 0x8002_0000 -> no ram_rd_en_o, rsp_valid_o at T+1, rsp_err_o=1, rdata=0.
